// File: rtl/ibex_dummy_ctrl_pkg.sv
// ibex_dummy_ctrl_pkg: shared types and CSR field layout for the dummy instruction controller
package ibex_dummy_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, UPDATE, HALT} ctrl_state_e;
  typedef struct packed {
    logic       en;
    logic [2:0] mask;
  } dummy_cfg_t;
  localparam int unsigned CfgEnBit   = 0;
  localparam int unsigned CfgMaskLsb = 1;
  localparam int unsigned CfgMaskMsb = 3;
  localparam int unsigned BudgetW    = 4;
  function automatic dummy_cfg_t cfg_from_csr(input logic [3:0] wdata);
    dummy_cfg_t c;
    c.en   = wdata[CfgEnBit];
    c.mask = wdata[CfgMaskMsb:CfgMaskLsb];
    return c;
  endfunction
endpackage

// File: rtl/ibex_dummy_budget.sv
// ibex_dummy_budget: rolling window counter with a per-window insertion budget
module ibex_dummy_budget
  import ibex_dummy_ctrl_pkg::*;
#(
  parameter int unsigned BudgetMax = 4,
  parameter int unsigned WindowW   = 6
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run,
  input  logic consume,
  input  logic hold,
  output logic budget_nonzero
);
  logic [WindowW-1:0] r_win;
  logic [BudgetW-1:0] r_budget;
  logic               w_step;
  logic               w_wrap;
  assign w_step = run & ~hold;
  assign w_wrap = w_step & (&r_win);
  assign budget_nonzero = r_budget != '0;
  // reload on wrap beats a same-cycle consume, so that acceptance goes uncharged
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_win    <= '0;
      r_budget <= BudgetW'(BudgetMax);
    end else begin
      if (w_step) r_win <= r_win + 1'b1;
      if (w_wrap) r_budget <= BudgetW'(BudgetMax);
      else if (consume & ~hold & budget_nonzero) r_budget <= r_budget - 1'b1;
    end
  end
endmodule

// File: rtl/ibex_dummy_instr_ctrl.sv
// ibex_dummy_instr_ctrl: stages CSR updates, applies them safely and rate-limits dummy insertion
module ibex_dummy_instr_ctrl
  import ibex_dummy_ctrl_pkg::*;
#(
  parameter int unsigned BudgetMax = 4,
  parameter int unsigned WindowW   = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        csr_cfg_we_i,
  input  logic [3:0]  csr_cfg_wdata_i,
  input  logic        csr_seed_we_i,
  input  logic [31:0] csr_seed_wdata_i,
  input  logic        insert_req_i,
  input  logic        id_in_ready_i,
  input  logic        debug_mode_i,
  output logic        dummy_instr_en_o,
  output logic [2:0]  dummy_instr_mask_o,
  output logic        dummy_instr_seed_en_o,
  output logic [31:0] dummy_instr_seed_o,
  output logic        insert_grant_o,
  output logic        update_pending_o,
  output logic [31:0] dummy_count_o
);
  ctrl_state_e r_state, w_state_nxt;
  dummy_cfg_t  r_cfg, r_cfg_stage, w_cfg_nxt;
  logic [31:0] r_seed_stage, r_count;
  logic        r_cfg_pend, r_seed_pend;
  logic        w_budget_nz, w_pending, w_stalled, w_accept, w_in_update;
  assign w_pending   = r_cfg_pend | r_seed_pend;
  assign w_in_update = r_state == UPDATE;
  assign w_stalled   = insert_grant_o & ~id_in_ready_i;
  assign w_accept    = insert_grant_o & id_in_ready_i;
  assign w_cfg_nxt   = (w_in_update & r_cfg_pend) ? r_cfg_stage : r_cfg;
  // grant and seed pulse are masked by reset so an aborted cycle leaves no side effects
  assign insert_grant_o        = (r_state == RUN) & insert_req_i & w_budget_nz & ~rst_i;
  assign dummy_instr_seed_en_o = w_in_update & r_seed_pend & ~rst_i;
  assign dummy_instr_seed_o    = dummy_instr_seed_en_o ? r_seed_stage : '0;
  assign dummy_instr_en_o      = (r_state == RUN) & r_cfg.en;
  assign dummy_instr_mask_o    = r_cfg.mask;
  assign update_pending_o      = w_pending;
  assign dummy_count_o         = r_count;
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, RUN: w_state_nxt = (w_pending & ~w_stalled & ~debug_mode_i) ? UPDATE :
                               debug_mode_i ? HALT : r_state;
      UPDATE:    w_state_nxt = w_cfg_nxt.en ? RUN : IDLE;
      HALT:      w_state_nxt = debug_mode_i ? HALT : w_pending ? UPDATE : r_cfg.en ? RUN : IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_cfg        <= '0;
      r_cfg_stage  <= '0;
      r_seed_stage <= '0;
      r_cfg_pend   <= 1'b0;
      r_seed_pend  <= 1'b0;
      r_count      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cfg       <= w_cfg_nxt;
      r_cfg_pend  <= csr_cfg_we_i | (r_cfg_pend & ~w_in_update);
      r_seed_pend <= csr_seed_we_i | (r_seed_pend & ~w_in_update);
      if (csr_cfg_we_i) r_cfg_stage <= cfg_from_csr(csr_cfg_wdata_i);
      if (csr_seed_we_i) r_seed_stage <= csr_seed_wdata_i;
      if (w_accept & ~(&r_count)) r_count <= r_count + 1'b1;
    end
  end
  ibex_dummy_budget #(
    .BudgetMax(BudgetMax),
    .WindowW  (WindowW)
  ) u_budget (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .run           (r_state == RUN),
    .consume       (w_accept),
    .hold          (r_state == HALT),
    .budget_nonzero(w_budget_nz)
  );
endmodule

// File: tb/tb_ibex_dummy_instr_ctrl.sv
// tb_ibex_dummy_instr_ctrl: directed scenarios with hand-computed expectations
module tb_ibex_dummy_instr_ctrl;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        csr_cfg_we_i = 1'b0;
  logic [3:0]  csr_cfg_wdata_i = '0;
  logic        csr_seed_we_i = 1'b0;
  logic [31:0] csr_seed_wdata_i = '0;
  logic        insert_req_i = 1'b0;
  logic        id_in_ready_i = 1'b0;
  logic        debug_mode_i = 1'b0;
  logic        dummy_instr_en_o;
  logic [2:0]  dummy_instr_mask_o;
  logic        dummy_instr_seed_en_o;
  logic [31:0] dummy_instr_seed_o;
  logic        insert_grant_o;
  logic        update_pending_o;
  logic [31:0] dummy_count_o;
  int          n_cmp = 0;
  int          n_bad = 0;
  always #5 clk = ~clk;
  ibex_dummy_instr_ctrl #(.BudgetMax(4), .WindowW(6)) dut (
    .clk_i                (clk),
    .rst_i                (rst_i),
    .csr_cfg_we_i         (csr_cfg_we_i),
    .csr_cfg_wdata_i      (csr_cfg_wdata_i),
    .csr_seed_we_i        (csr_seed_we_i),
    .csr_seed_wdata_i     (csr_seed_wdata_i),
    .insert_req_i         (insert_req_i),
    .id_in_ready_i        (id_in_ready_i),
    .debug_mode_i         (debug_mode_i),
    .dummy_instr_en_o     (dummy_instr_en_o),
    .dummy_instr_mask_o   (dummy_instr_mask_o),
    .dummy_instr_seed_en_o(dummy_instr_seed_en_o),
    .dummy_instr_seed_o   (dummy_instr_seed_o),
    .insert_grant_o       (insert_grant_o),
    .update_pending_o     (update_pending_o),
    .dummy_count_o        (dummy_count_o)
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_i = 1'b1;
    cyc();
    cyc();
    rst_i = 1'b0;
    #1;
    n_cmp++;
    if ({dummy_instr_en_o, dummy_instr_mask_o, dummy_instr_seed_en_o, insert_grant_o, update_pending_o} !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0000000", {dummy_instr_en_o, dummy_instr_mask_o, dummy_instr_seed_en_o, insert_grant_o, update_pending_o});
    end
    n_cmp++;
    if (dummy_count_o !== 32'd0) begin n_bad++; $display("FAIL reset_count: got %h want 0", dummy_count_o); end
    n_cmp++;
    if (dummy_instr_seed_o !== 32'd0) begin n_bad++; $display("FAIL reset_seed: got %h want 0", dummy_instr_seed_o); end
    cyc();
  endtask
  task automatic test_cfg();
    csr_cfg_we_i = 1'b1;
    csr_cfg_wdata_i = 4'b0111;
    #1;
    cyc();
    csr_cfg_we_i = 1'b0;
    #1;
    n_cmp++;
    if (update_pending_o !== 1'b1) begin n_bad++; $display("FAIL cfg_pending: got %b want 1", update_pending_o); end
    cyc();
    #1;
    n_cmp++;
    if (dummy_instr_en_o !== 1'b0) begin n_bad++; $display("FAIL cfg_update_en: got %b want 0", dummy_instr_en_o); end
    cyc();
    #1;
    n_cmp++;
    if ({dummy_instr_en_o, dummy_instr_mask_o, update_pending_o} !== 5'b1_011_0) begin
      n_bad++;
      $display("FAIL cfg_run: got %b want 10110", {dummy_instr_en_o, dummy_instr_mask_o, update_pending_o});
    end
  endtask
  task automatic test_budget();
    logic [63:0] v;
    for (int w = 0; w < 2; w++) begin
      v = '0;
      for (int k = 0; k < 64; k++) begin
        insert_req_i = 1'b1;
        id_in_ready_i = 1'b1;
        #1;
        v[k] = insert_grant_o;
        cyc();
      end
      n_cmp++;
      if (v !== 64'h0000_0000_0000_000F) begin n_bad++; $display("FAIL budget_window%0d: got %h want 000000000000000f", w, v); end
    end
    n_cmp++;
    if (dummy_count_o !== 32'd8) begin n_bad++; $display("FAIL budget_count: got %0d want 8", dummy_count_o); end
  endtask
  task automatic test_wrap();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 64; k++) begin
      insert_req_i = (k == 63);
      id_in_ready_i = 1'b1;
      #1;
      v[k] = insert_grant_o;
      cyc();
    end
    n_cmp++;
    if (v !== 64'h8000_0000_0000_0000) begin n_bad++; $display("FAIL wrap_grant: got %h want 8000000000000000", v); end
    v = '0;
    for (int k = 0; k < 64; k++) begin
      insert_req_i = 1'b1;
      #1;
      v[k] = insert_grant_o;
      cyc();
    end
    n_cmp++;
    if (v !== 64'h0000_0000_0000_000F) begin n_bad++; $display("FAIL wrap_reload: got %h want 000000000000000f", v); end
    n_cmp++;
    if (dummy_count_o !== 32'd13) begin n_bad++; $display("FAIL wrap_count: got %0d want 13", dummy_count_o); end
  endtask
  task automatic test_stall();
    int pulses;
    pulses = 0;
    insert_req_i = 1'b1;
    id_in_ready_i = 1'b0;
    csr_seed_we_i = 1'b1;
    csr_seed_wdata_i = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if (insert_grant_o !== 1'b1) begin n_bad++; $display("FAIL stall_grant0: got %b want 1", insert_grant_o); end
    pulses += int'(dummy_instr_seed_en_o);
    cyc();
    csr_seed_we_i = 1'b0;
    for (int s = 1; s < 3; s++) begin
      #1;
      n_cmp++;
      if ({insert_grant_o, update_pending_o} !== 2'b11) begin
        n_bad++;
        $display("FAIL stall_hold%0d: got %b want 11", s, {insert_grant_o, update_pending_o});
      end
      pulses += int'(dummy_instr_seed_en_o);
      cyc();
    end
    id_in_ready_i = 1'b1;
    #1;
    pulses += int'(dummy_instr_seed_en_o);
    cyc();
    insert_req_i = 1'b0;
    #1;
    n_cmp++;
    if ({dummy_instr_seed_en_o, dummy_instr_en_o} !== 2'b10) begin
      n_bad++;
      $display("FAIL stall_update: got %b want 10", {dummy_instr_seed_en_o, dummy_instr_en_o});
    end
    n_cmp++;
    if (dummy_instr_seed_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL stall_seed: got %h want deadbeef", dummy_instr_seed_o); end
    pulses += int'(dummy_instr_seed_en_o);
    cyc();
    #1;
    pulses += int'(dummy_instr_seed_en_o);
    n_cmp++;
    if ({dummy_instr_en_o, update_pending_o} !== 2'b10) begin
      n_bad++;
      $display("FAIL stall_resume: got %b want 10", {dummy_instr_en_o, update_pending_o});
    end
    n_cmp++;
    if (pulses !== 1) begin n_bad++; $display("FAIL stall_pulses: got %0d want 1", pulses); end
    cyc();
  endtask
  task automatic test_halt();
    logic [63:0] v;
    debug_mode_i = 1'b1;
    insert_req_i = 1'b0;
    #1;
    cyc();
    csr_cfg_we_i = 1'b1;
    csr_cfg_wdata_i = 4'b0111;
    insert_req_i = 1'b1;
    for (int h = 1; h < 7; h++) begin
      if (h == 2) csr_cfg_we_i = 1'b0;
      if (h == 5) debug_mode_i = 1'b0;
      #1;
      n_cmp++;
      if ({dummy_instr_en_o, insert_grant_o} !== 2'b00) begin
        n_bad++;
        $display("FAIL halt_quiet%0d: got %b want 00", h, {dummy_instr_en_o, insert_grant_o});
      end
      if (h >= 2 && h <= 4) begin
        n_cmp++;
        if (update_pending_o !== 1'b1) begin n_bad++; $display("FAIL halt_pending%0d: got %b want 1", h, update_pending_o); end
      end
      cyc();
    end
    #1;
    n_cmp++;
    if (dummy_instr_en_o !== 1'b1) begin n_bad++; $display("FAIL halt_exit_en: got %b want 1", dummy_instr_en_o); end
    v = '0;
    for (int k = 0; k < 64; k++) begin
      insert_req_i = 1'b1;
      id_in_ready_i = 1'b1;
      #1;
      v[k] = insert_grant_o;
      cyc();
    end
    n_cmp++;
    if (v !== 64'h3C00_0000_0000_0007) begin n_bad++; $display("FAIL halt_window: got %h want 3c00000000000007", v); end
    n_cmp++;
    if (dummy_count_o !== 32'd21) begin n_bad++; $display("FAIL halt_count: got %0d want 21", dummy_count_o); end
  endtask
  task automatic test_reset_update();
    insert_req_i = 1'b0;
    csr_seed_we_i = 1'b1;
    csr_seed_wdata_i = 32'h1234_5678;
    #1;
    cyc();
    csr_seed_we_i = 1'b0;
    #1;
    n_cmp++;
    if (update_pending_o !== 1'b1) begin n_bad++; $display("FAIL rstupd_pending: got %b want 1", update_pending_o); end
    cyc();
    rst_i = 1'b1;
    #1;
    n_cmp++;
    if ({dummy_instr_seed_en_o, dummy_instr_seed_o} !== 33'd0) begin
      n_bad++;
      $display("FAIL rstupd_nopulse: got %b/%h want 0/0", dummy_instr_seed_en_o, dummy_instr_seed_o);
    end
    cyc();
    rst_i = 1'b0;
    #1;
    n_cmp++;
    if ({dummy_instr_en_o, dummy_instr_mask_o, dummy_instr_seed_en_o, insert_grant_o, update_pending_o} !== 7'd0) begin
      n_bad++;
      $display("FAIL rstupd_flags: got %b want 0000000", {dummy_instr_en_o, dummy_instr_mask_o, dummy_instr_seed_en_o, insert_grant_o, update_pending_o});
    end
    n_cmp++;
    if (dummy_count_o !== 32'd0) begin n_bad++; $display("FAIL rstupd_count: got %0d want 0", dummy_count_o); end
    cyc();
    #1;
    n_cmp++;
    if ({dummy_instr_seed_en_o, dummy_instr_en_o} !== 2'b00) begin
      n_bad++;
      $display("FAIL rstupd_idle: got %b want 00", {dummy_instr_seed_en_o, dummy_instr_en_o});
    end
    cyc();
  endtask
  task automatic test_back_to_back();
    csr_cfg_we_i = 1'b1;
    csr_cfg_wdata_i = 4'b0011;
    #1;
    cyc();
    csr_cfg_we_i = 1'b0;
    #1;
    cyc();
    csr_cfg_we_i = 1'b1;
    csr_cfg_wdata_i = 4'b0100;
    #1;
    n_cmp++;
    if (dummy_instr_en_o !== 1'b0) begin n_bad++; $display("FAIL b2b_update1: got %b want 0", dummy_instr_en_o); end
    cyc();
    csr_cfg_we_i = 1'b0;
    #1;
    n_cmp++;
    if ({dummy_instr_en_o, dummy_instr_mask_o, update_pending_o} !== 5'b1_001_1) begin
      n_bad++;
      $display("FAIL b2b_first: got %b want 10011", {dummy_instr_en_o, dummy_instr_mask_o, update_pending_o});
    end
    cyc();
    #1;
    n_cmp++;
    if ({dummy_instr_en_o, update_pending_o} !== 2'b01) begin
      n_bad++;
      $display("FAIL b2b_update2: got %b want 01", {dummy_instr_en_o, update_pending_o});
    end
    cyc();
    #1;
    n_cmp++;
    if ({dummy_instr_en_o, dummy_instr_mask_o, update_pending_o} !== 5'b0_010_0) begin
      n_bad++;
      $display("FAIL b2b_second: got %b want 00100", {dummy_instr_en_o, dummy_instr_mask_o, update_pending_o});
    end
    cyc();
  endtask
  initial begin
    #1;
    test_reset();
    test_cfg();
    test_budget();
    test_wrap();
    test_stall();
    test_halt();
    test_reset_update();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ibex_dummy_instr_ctrl.md
IBEX_DUMMY_INSTR_CTRL -- requirements
Module: ibex_dummy_instr_ctrl

Interface
REQ-001 SHALL have parameter BudgetMax, default 4: dummy insertions allowed per window, range 1..15.
REQ-002 SHALL have parameter WindowW, default 6: window length is 2^WindowW cycles.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port csr_cfg_we_i, input, 1: config write strobe.
REQ-006 SHALL have port csr_cfg_wdata_i, input, 4: bit0 enable, bits3:1 mask.
REQ-007 SHALL have port csr_seed_we_i, input, 1: seed write strobe.
REQ-008 SHALL have port csr_seed_wdata_i, input, 32: seed value.
REQ-009 SHALL have port insert_req_i, input, 1: the generator requests a dummy insertion.
REQ-010 SHALL have port id_in_ready_i, input, 1: the ID stage accepts the instruction.
REQ-011 SHALL have port debug_mode_i, input, 1: the core is in debug mode.
REQ-012 SHALL have port dummy_instr_en_o, output, 1: generator enable.
REQ-013 SHALL have port dummy_instr_mask_o, output, 3: generator mask.
REQ-014 SHALL have port dummy_instr_seed_en_o, output, 1: one-cycle seed load pulse.
REQ-015 SHALL have port dummy_instr_seed_o, output, 32: seed data, valid while seed_en_o is high.
REQ-016 SHALL have port insert_grant_o, output, 1: insertion permitted this cycle.
REQ-017 SHALL have port update_pending_o, output, 1: a cfg or seed write is staged but not yet applied.
REQ-018 SHALL have port dummy_count_o, output, 32: count of accepted dummies, saturating.

Function
REQ-019 SHALL implement the states IDLE, RUN, UPDATE and HALT.
REQ-020 SHALL capture a cfg write into a staging register and set cfg_pend; a seed write SHALL likewise set seed_pend. A later write SHALL overwrite the staged value.
REQ-021 SHALL define update_pending_o = cfg_pend | seed_pend.
REQ-022 SHALL define stalled = insert_grant_o & ~id_in_ready_i.
REQ-023 SHALL transition from IDLE or RUN to UPDATE when update_pending_o & ~stalled & ~debug_mode_i.
REQ-024 SHALL stay in UPDATE for exactly 1 cycle, in which:
- dummy_instr_en_o = 0 and insert_grant_o = 0;
- seed_en_o pulses if seed_pend is set;
- cfg is applied if cfg_pend is set;
- both pend flags clear, unless a new write arrives in that same cycle, which stays pending.
REQ-025 SHALL leave UPDATE for RUN if the applied enable = 1, otherwise for IDLE.
REQ-026 SHALL transition from IDLE or RUN to HALT when debug_mode_i = 1 and there is no UPDATE transition. Debug takes priority over pending updates.
REQ-027 SHALL, in HALT:
- hold dummy_instr_en_o = 0 and insert_grant_o = 0;
- freeze the window counter and budget;
- keep accepting CSR writes.
On debug_mode_i = 0 it SHALL go to UPDATE if pending, otherwise to RUN/IDLE per enable.
REQ-028 SHALL drive dummy_instr_en_o = applied enable in RUN and 0 in every other state.
REQ-029 SHALL define insert_grant_o = (state == RUN) & insert_req_i & (budget != 0), combinationally.
REQ-030 SHALL treat an insertion as accepted when insert_grant_o & id_in_ready_i. An accepted insertion SHALL decrement the budget by 1 and increment dummy_count_o by 1, saturating at 0xFFFFFFFF.
REQ-031 SHALL increment a WindowW-bit window counter only in RUN, wrapping modulo 2^WindowW.
REQ-032 SHALL reload budget to BudgetMax on the cycle the window counter wraps to 0. If an acceptance occurs in that same cycle, the reload SHALL win and the acceptance SHALL NOT be charged.
REQ-033 SHALL never let the budget underflow; budget = 0 forces the grant low.
REQ-034 SHALL leave the window counter and budget unchanged when entering UPDATE.

Reset
REQ-035 SHALL, on rst_i = 1 at a clock edge, set:
- state = IDLE;
- all outputs 0;
- applied and staged cfg = 0, seed staging = 0, pend flags = 0;
- window counter = 0, budget = BudgetMax, dummy_count_o = 0.
REQ-036 SHALL abort any in-progress UPDATE or grant on reset, with no seed pulse emitted.

Structure
REQ-037 SHALL place the state enum, the cfg struct (enable, mask[2:0]) and the CSR field bit positions in the package ibex_dummy_ctrl_pkg.
REQ-038 SHALL implement the window counter and budget as the sub-module ibex_dummy_budget. Its ports are run, consume and hold, and its output is budget_nonzero.

Verification
REQ-039 Cfg write 0b0111 in IDLE -> UPDATE for 1 cycle, then RUN; en_o = 1 and mask_o = 3'b011 from cycle +2.
REQ-040 Seed write 0xDEADBEEF while stalled (grant = 1, ready = 0 for 3 cycles) -> no UPDATE until ready; seed_en_o pulses exactly once with 0xDEADBEEF.
REQ-041 BudgetMax = 4, WindowW = 6, insert_req and ready held high -> exactly 4 grants per 64-cycle window; grant is low once budget = 0 until the wrap.
REQ-042 Acceptance coinciding with the window wrap -> budget = 4 afterwards, not 3.
REQ-043 debug_mode_i asserted mid-RUN with a cfg write during HALT -> en_o = 0 throughout; on exit, UPDATE then RUN; the window counter resumes from its frozen value.
REQ-044 rst_i asserted in the UPDATE cycle -> no seed pulse; next cycle IDLE with all outputs 0 and dummy_count_o = 0.
